// File: rtl/boot_mem_sequencer.sv
// Block-RAM port owner: a UART bootloader fills memory from BASE_ADDR after reset,
// then the port passes through to the CPU load/store path until the next reset.
module boot_mem_sequencer #(
   parameter int unsigned       ADDR_W    = 19,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic              boot_done,
   output logic [31:0]       words_loaded
);

   typedef enum logic [1:0] {S_HDR, S_DATA, S_WR, S_RUN} state_e;

   state_e      state_q, state_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] count_q, count_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic [31:0] words_q, words_d;
   logic        rvalid_q, rvalid_d;

   logic        byteTake;
   logic        lastByte;
   logic [31:0] fullWord;
   logic [31:0] wordsInc;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_HDR;
         bidx_q   <= 2'd0;
         shift_q  <= 32'd0;
         count_q  <= 32'd0;
         wbuf_q   <= 32'd0;
         words_q  <= 32'd0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bidx_q   <= bidx_d;
         shift_q  <= shift_d;
         count_q  <= count_d;
         wbuf_q   <= wbuf_d;
         words_q  <= words_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Bytes keep being assembled in S_WR so a byte landing in the write cycle
   // becomes byte 0 of the next word; bidx wraps to 0 on the 4th byte.
   always_comb begin
      byteTake = rx_valid && (state_q != S_RUN);
      lastByte = byteTake && (bidx_q == 2'd3);
      fullWord = {rx_data, shift_q[23:0]};
      wordsInc = words_q + 32'd1;
      state_d  = state_q;
      bidx_d   = bidx_q;
      shift_d  = shift_q;
      count_d  = count_q;
      wbuf_d   = wbuf_q;
      words_d  = words_q;
      rvalid_d = (state_q == S_RUN) && cpu_req && !cpu_we;
      if (byteTake) begin
         shift_d[{bidx_q, 3'b000} +: 8] = rx_data;
         bidx_d = bidx_q + 2'd1;
      end
      case (state_q)
         S_HDR: begin
            if (lastByte) begin
               count_d = fullWord;
               state_d = (fullWord == 32'd0) ? S_RUN : S_DATA;
            end
         end
         S_DATA: begin
            if (lastByte) begin
               wbuf_d  = fullWord;
               state_d = S_WR;
            end
         end
         S_WR: begin
            words_d = wordsInc;
            state_d = (wordsInc == count_q) ? S_RUN : S_DATA;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      mem_addr  = BASE_ADDR + words_q[ADDR_W-1:0];
      mem_wdata = wbuf_q;
      mem_we    = (state_q == S_WR);
      if (state_q == S_RUN) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_req && cpu_we;
      end
   end

   assign cpu_ready    = (state_q == S_RUN);
   assign boot_done    = cpu_ready;
   assign cpu_rvalid   = rvalid_q;
   assign cpu_rdata    = mem_rdata;
   assign words_loaded = words_q;

endmodule
